// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over
// a window of GATE_CYCLES clocks and reports the count with a one-cycle strobe.
module freq_meter #(
  parameter int CLK         = 50000000,
  parameter int GATE_CYCLES = 50000000,
  parameter int GW          = 26,
  parameter int CW          = 26,
  parameter bit CONT        = 1'b0
) (
  input  logic          clk_50M,
  input  logic          cr,
  input  logic          sig_in,
  input  logic          start,
  output logic [CW-1:0] freq,
  output logic          ovf,
  output logic          valid,
  output logic          busy
);

  if (GATE_CYCLES < 2 || CLK <= 0 || (GATE_CYCLES >> GW) != 0) begin : g_bad_cfg
    $error("freq_meter: invalid GATE_CYCLES/GW/CLK configuration");
  end

  typedef enum logic [2:0] {IDLE, WARM, ARM, GATE, DONE} state_t;

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state;
  logic          s1, s2, s3;
  logic          sig_edge;
  logic [GW-1:0] gate_cnt;
  logic [CW-1:0] edge_cnt;
  logic [1:0]    warm_cnt;
  logic          sat;
  logic [CW-1:0] cnt_next;
  logic          sat_next;

  assign sig_edge = s2 & ~s3;

  // Saturating edge count; sat marks that an edge arrived with the counter full.
  always_comb begin
    cnt_next = edge_cnt;
    sat_next = sat;
    if (sig_edge) begin
      if (edge_cnt == CNT_MAX) sat_next = 1'b1;
      else                     cnt_next = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (cr) begin
      state    <= WARM;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      warm_cnt <= '0;
      sat      <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b1;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;
      case (state)
        // Three cycles to flush stale synchronizer contents before counting.
        WARM: begin
          if (warm_cnt == 2'd2) begin
            state <= CONT ? ARM : IDLE;
            busy  <= CONT;
          end else begin
            warm_cnt <= warm_cnt + 2'd1;
          end
        end
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          state    <= GATE;
        end
        // The last gate cycle still counts its edge; the result lands with valid.
        GATE: begin
          edge_cnt <= cnt_next;
          sat      <= sat_next;
          gate_cnt <= gate_cnt + 1'b1;
          if (gate_cnt == GATE_LAST) begin
            state <= DONE;
            freq  <= cnt_next;
            ovf   <= sat_next;
            valid <= 1'b1;
          end
        end
        DONE: begin
          state <= CONT ? ARM : IDLE;
          busy  <= CONT;
        end
        default: begin
          state <= WARM;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
